// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed, checksummed program image byte by
// byte, writes it word by word into memory from LOAD_BASE, then releases the
// core from reset. The core reset doubles as the memory-port select.
module boot_loader #(
    parameter logic [31:0] LOAD_BASE     = 32'd64,
    parameter int          MAX_WORDS     = 16384,
    parameter int          RELEASE_DELAY = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        mem_wr_en,
    output logic [3:0]  mem_wr_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        INIT, HDR, DATA, CSUM, RELEASE, RUN, ERROR
    } state_t;

    // Last value of the release counter before moving to RUN; a zero delay
    // skips RELEASE entirely.
    localparam logic [7:0] REL_LAST = (RELEASE_DELAY > 0) ? 8'(RELEASE_DELAY - 1) : 8'd0;
    localparam bit         REL_SKIP = (RELEASE_DELAY == 0);

    state_t      state, next_state;
    logic        armed;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [31:0] n_words;
    logic [31:0] word_cnt;
    logic [7:0]  csum;
    logic [7:0]  rel_cnt;

    logic        in_ready_d, core_rst_d, done_d, error_d;

    logic        accept;
    logic        word_end;
    logic [31:0] full_word;

    assign accept    = in_valid && in_ready;
    assign word_end  = accept && (byte_cnt == 2'd3);
    assign full_word = {in_byte, shift};

    // State register; `armed` stretches INIT so the first byte is taken only
    // from the second edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            armed <= 1'b0;
        end else begin
            state <= next_state;
            armed <= 1'b1;
        end
    end

    // Next-state decision from the current state and the byte being accepted.
    always_comb begin
        next_state = state;
        case (state)
            INIT: begin
                if (armed) next_state = HDR;
            end
            HDR: begin
                if (word_end) begin
                    if (full_word == 32'd0 || full_word > 32'(MAX_WORDS))
                        next_state = ERROR;
                    else
                        next_state = DATA;
                end
            end
            DATA: begin
                if (word_end && word_cnt == n_words - 32'd1) next_state = CSUM;
            end
            CSUM: begin
                if (accept) begin
                    if (in_byte != csum)
                        next_state = ERROR;
                    else if (REL_SKIP)
                        next_state = RUN;
                    else
                        next_state = RELEASE;
                end
            end
            RELEASE: begin
                if (rel_cnt == REL_LAST) next_state = RUN;
            end
            RUN:     next_state = RUN;
            ERROR:   next_state = ERROR;
            default: next_state = INIT;
        endcase
    end

    // Next values of the registered status outputs; in_ready follows the state
    // being entered so it drops on the same edge that takes the checksum.
    always_comb begin
        in_ready_d = (next_state == HDR) || (next_state == DATA) || (next_state == CSUM);
        core_rst_d = (state != RUN);
        done_d     = (state == RUN);
        error_d    = (state == ERROR);
    end

    // Datapath: byte assembly, word counting, checksum, release timer and
    // all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt    <= 2'd0;
            shift       <= 24'd0;
            n_words     <= 32'd0;
            word_cnt    <= 32'd0;
            csum        <= 8'd0;
            rel_cnt     <= 8'd0;
            in_ready    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_mask <= 4'd0;
            mem_addr    <= 32'd0;
            mem_data    <= 32'd0;
            core_rst    <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            in_ready    <= in_ready_d;
            core_rst    <= core_rst_d;
            done        <= done_d;
            error       <= error_d;
            mem_wr_en   <= 1'b0;
            mem_wr_mask <= 4'd0;
            if (accept && (state == HDR || state == DATA)) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= {in_byte, shift[23:8]};
            end
            if (state == HDR && word_end) begin
                n_words <= full_word;
            end
            if (state == DATA && accept) begin
                csum <= csum + in_byte;
            end
            if (state == DATA && word_end) begin
                mem_wr_en   <= 1'b1;
                mem_wr_mask <= 4'hF;
                mem_addr    <= LOAD_BASE + (word_cnt << 2);
                mem_data    <= full_word;
                word_cnt    <= word_cnt + 32'd1;
            end
            if (state == RELEASE) begin
                rel_cnt <= rel_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed testbench for boot_loader: nominal, gapped, bad checksum, bad
// headers, mid-load abort, and an address-wrapping zero-delay instance.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'd0;

    logic        in_ready, mem_wr_en, core_rst, done, error;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_addr, mem_data;

    logic        b_in_ready, b_mem_wr_en, b_core_rst, b_done, b_error;
    logic [3:0]  b_mem_wr_mask;
    logic [31:0] b_mem_addr, b_mem_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_total = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0]  wm[$];
    int          wc[$];
    logic [31:0] w2a[$];
    logic [7:0]  img[$];
    int          tacc[0:15];
    int          wbase, w2base, abase;
    int          t_d1, t_e1, t_d2;

    boot_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask),
        .mem_addr(mem_addr), .mem_data(mem_data), .core_rst(core_rst),
        .done(done), .error(error)
    );

    boot_loader #(.LOAD_BASE(32'hFFFF_FFFC), .MAX_WORDS(16384), .RELEASE_DELAY(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(b_in_ready), .mem_wr_en(b_mem_wr_en), .mem_wr_mask(b_mem_wr_mask),
        .mem_addr(b_mem_addr), .mem_data(b_mem_data), .core_rst(b_core_rst),
        .done(b_done), .error(b_error)
    );

    always #5 clk = ~clk;

    // Edge counter used to timestamp accepted bytes and writes.
    always @(posedge clk) cyc <= cyc + 1;

    // Count bytes actually consumed by the main instance.
    always @(posedge clk) if (in_valid && in_ready) acc_total <= acc_total + 1;

    // Log memory writes of both instances away from the active edge.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            wm.push_back(mem_wr_mask);
            wc.push_back(cyc);
        end
        if (b_mem_wr_en) w2a.push_back(b_mem_addr);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int idx);
        logic rdy;
        bit   taken;
        taken = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int i = 0; i < 50 && !taken; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                taken = 1'b1;
                tacc[idx] = cyc;
            end
            @(negedge clk);
        end
        if (!taken) begin
            tacc[idx] = -1;
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic applyStimulus(input int gap_max, input logic hold);
        for (int i = 0; i < img.size(); i++) begin
            if (gap_max > 0) begin
                int g;
                g = int'($urandom_range(gap_max, 0));
                in_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            sendByte(img[i], i);
        end
        in_valid = hold;
        in_byte  = 8'hA5;
    endtask

    task automatic doReset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 checkOutput("init_ready_lo", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 checkOutput("init_ready_hi", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        wbase  = wa.size();
        w2base = w2a.size();
        abase  = acc_total;
    endtask

    task automatic waitFlags(input int limit);
        t_d1 = -1; t_e1 = -1; t_d2 = -1;
        for (int i = 0; i < limit; i++) begin
            if (done && t_d1 < 0)   t_d1 = cyc;
            if (error && t_e1 < 0)  t_e1 = cyc;
            if (b_done && t_d2 < 0) t_d2 = cyc;
            @(negedge clk);
        end
    endtask

    task automatic checkNominal(input string tag);
        checkOutput({tag, ".nwr"}, 32'(wa.size() - wbase), 32'd2);
        if (wa.size() - wbase >= 2) begin
            checkOutput({tag, ".a0"}, wa[wbase], 32'd64);
            checkOutput({tag, ".d0"}, wd[wbase], 32'h1234_5678);
            checkOutput({tag, ".m0"}, {28'd0, wm[wbase]}, 32'hF);
            checkOutput({tag, ".t0"}, wc[wbase], tacc[7]);
            checkOutput({tag, ".a1"}, wa[wbase+1], 32'd68);
            checkOutput({tag, ".d1"}, wd[wbase+1], 32'hDEAD_BEEF);
            checkOutput({tag, ".m1"}, {28'd0, wm[wbase+1]}, 32'hF);
            checkOutput({tag, ".t1"}, wc[wbase+1], tacc[11]);
        end
        checkOutput({tag, ".nwr2"}, 32'(w2a.size() - w2base), 32'd2);
        if (w2a.size() - w2base >= 2) begin
            checkOutput({tag, ".wrap_a0"}, w2a[w2base], 32'hFFFF_FFFC);
            checkOutput({tag, ".wrap_a1"}, w2a[w2base+1], 32'h0000_0000);
        end
        waitFlags(40);
        checkOutput({tag, ".done_t"}, t_d1, tacc[12] + 17);
        checkOutput({tag, ".done0_t"}, t_d2, tacc[12] + 1);
        checkOutput({tag, ".err"}, t_e1, -1);
        checkOutput({tag, ".core_rst"}, {31'd0, core_rst}, 32'd0);
        checkOutput({tag, ".wrap_err"}, {31'd0, b_error}, 32'd0);
        repeat (10) @(negedge clk);
        checkOutput({tag, ".accepted"}, acc_total - abase, 32'd13);
        checkOutput({tag, ".ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        checkOutput("rst.in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst.wr_en", {31'd0, mem_wr_en}, 32'd0);
        checkOutput("rst.mask", {28'd0, mem_wr_mask}, 32'd0);
        checkOutput("rst.addr", mem_addr, 32'd0);
        checkOutput("rst.data", mem_data, 32'd0);
        checkOutput("rst.core_rst", {31'd0, core_rst}, 32'd1);
        checkOutput("rst.done", {31'd0, done}, 32'd0);
        checkOutput("rst.error", {31'd0, error}, 32'd0);

        $display("[TB] nominal back-to-back load");
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        doReset();
        applyStimulus(0, 1'b0);
        checkNominal("nominal");

        $display("[TB] gapped load, valid held high afterwards");
        doReset();
        applyStimulus(5, 1'b1);
        checkNominal("gapped");
        in_valid = 1'b0;

        $display("[TB] bad checksum");
        img[12] = 8'h4D;
        doReset();
        applyStimulus(0, 1'b1);
        waitFlags(30);
        checkOutput("badsum.err_t", t_e1, tacc[12] + 1);
        checkOutput("badsum.done", t_d1, -1);
        checkOutput("badsum.nwr", 32'(wa.size() - wbase), 32'd2);
        checkOutput("badsum.core_rst", {31'd0, core_rst}, 32'd1);
        checkOutput("badsum.ready", {31'd0, in_ready}, 32'd0);
        checkOutput("badsum.accepted", acc_total - abase, 32'd13);

        $display("[TB] zero-length header");
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        doReset();
        applyStimulus(0, 1'b1);
        waitFlags(20);
        checkOutput("hdr0.err_t", t_e1, tacc[3] + 1);
        checkOutput("hdr0.nwr", 32'(wa.size() - wbase), 32'd0);
        checkOutput("hdr0.core_rst", {31'd0, core_rst}, 32'd1);
        checkOutput("hdr0.accepted", acc_total - abase, 32'd4);

        $display("[TB] oversized header");
        img = '{8'h01, 8'h40, 8'h00, 8'h00};
        doReset();
        applyStimulus(0, 1'b1);
        waitFlags(20);
        checkOutput("hdrbig.err_t", t_e1, tacc[3] + 1);
        checkOutput("hdrbig.nwr", 32'(wa.size() - wbase), 32'd0);
        checkOutput("hdrbig.accepted", acc_total - abase, 32'd4);

        $display("[TB] reset during payload, then reload");
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
        doReset();
        applyStimulus(0, 1'b0);
        checkOutput("abort.nwr_before", 32'(wa.size() - wbase), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort.core_rst", {31'd0, core_rst}, 32'd1);
        checkOutput("abort.ready", {31'd0, in_ready}, 32'd0);
        checkOutput("abort.addr", mem_addr, 32'd0);
        checkOutput("abort.data", mem_data, 32'd0);
        checkOutput("abort.done", {31'd0, done}, 32'd0);
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        doReset();
        applyStimulus(0, 1'b0);
        checkNominal("reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Boot-time program loader that sits between the host byte stream and the shared instruction/data memory. It holds `steel_core_top` in reset, receives a length-prefixed, checksummed image one byte at a time, and writes it word by word into memory starting at the core boot address. After the image validates, it releases the core reset and hands the memory port back to the core. While `core_rst` is high, the top level routes the memory data port (address, write enable, mask, write data) from this block; otherwise it routes them from the core.

## Interface
Parameters:
- `LOAD_BASE`, default 32'd64: byte address of the first image word. Equals the core `BOOT_ADDRESS`.
- `MAX_WORDS`, default 16384: largest accepted word count N.
- `RELEASE_DELAY`, default 16: cycles between checksum acceptance and `core_rst` deassertion. Legal range 0..255.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_byte` is valid this cycle.
- `in_byte`  in  8  image byte.
- `in_ready`  out  1  loader accepts a byte this cycle. A transfer occurs when `in_valid && in_ready`.
- `mem_wr_en`  out  1  one-cycle word write strobe.
- `mem_wr_mask`  out  4  byte enables; 4'b1111 whenever `mem_wr_en`=1.
- `mem_addr`  out  32  write byte address.
- `mem_data`  out  32  write data.
- `core_rst`  out  1  core reset; also the memory-port select (1 = loader owns the port).
- `done`  out  1  image loaded and core released.
- `error`  out  1  load failed; sticky until `rst`.

## Operation
- Stream format, all little-endian:
  - 4 header bytes: word count N.
  - 4·N payload bytes: word k is bytes 4k..4k+3, with byte 4k in bits [7:0].
  - 1 checksum byte: sum of all payload bytes mod 256.
- States:
  - INIT: single cycle after reset release; → HDR.
  - HDR: collect 4 bytes. On the 4th byte, if N==0 or N>MAX_WORDS → ERROR, else → DATA.
  - DATA: collect bytes and accumulate the checksum (8-bit wrapping add). Each 4th byte of a word issues a write. After word N-1 is complete → CSUM.
  - CSUM: one byte. If it equals the accumulated sum → RELEASE, else → ERROR.
  - RELEASE: count RELEASE_DELAY cycles → RUN.
  - RUN: terminal. `core_rst`=0, `done`=1.
  - ERROR: terminal. `error`=1, `core_rst` stays 1, input ignored.
- `in_ready`=1 only in HDR, DATA and CSUM. Bytes offered in other states are not consumed.
- Write address for word k is `LOAD_BASE + 4·k`, computed mod 2^32; wrap-around is permitted and not flagged.
- An idle `in_valid` gap of any length in any accepting state causes no state change.
- An `in_valid` value of X while `in_ready`=0 must not affect state.

## Timing
- Reset values, forced asynchronously and immediately on `rst`:
  - state INIT
  - `in_ready`=0, `mem_wr_en`=0, `mem_wr_mask`=0, `mem_addr`=0, `mem_data`=0
  - `core_rst`=1, `done`=0, `error`=0
  - byte, word and checksum counters cleared
- All outputs are registered.
- `in_ready` goes to 1 at the second rising edge after `rst` falls (INIT → HDR).
- Write latency: when the 4th byte of word k is accepted at edge t, `mem_wr_en`=1 with `mem_addr`/`mem_data` valid during the cycle after t, for exactly one cycle. `mem_wr_en` is 0 on all other cycles.
- Back-to-back bytes every cycle give at most one write per 4 cycles, so writes never collide.
- The final word's write may coincide with acceptance of the checksum byte. This is legal; the write still completes.
- Checksum byte accepted at edge t:
  - `in_ready`=0 after t.
  - Good checksum: `core_rst` falls and `done` rises together at edge t+1+RELEASE_DELAY.
  - Bad checksum: `error` rises at edge t+1.
- Header failure: `error` rises at the edge after the 4th header byte. No memory write is ever issued for that image.
- `rst` asserted mid-load aborts immediately: `core_rst` returns to 1 and any partially assembled word is discarded. Words already written stay in memory and are simply overwritten by the next load.
- `rst` asserted in RUN re-enters loading; the core is held in reset again.

## Test plan
- Nominal load: stream 02 00 00 00, 78 56 34 12, EF BE AD DE, 4C back-to-back.
  - Expect write addr 64 data 0x12345678, then addr 68 data 0xDEADBEEF, each `mask`=4'hF.
  - `core_rst` falls and `done` rises 17 edges after the checksum byte is accepted.
- Same image with checksum 4D → `error`=1 one edge later, no further writes, `core_rst` held 1, `in_ready`=0.
- Header 00 00 00 00 → `error`=1, zero writes. Header with N = MAX_WORDS+1 (01 40 00 00) → `error`=1, zero writes.
- Nominal image with random 0–5 cycle `in_valid` gaps and `in_valid` held high in RUN → identical writes and timing relative to the final byte, and no bytes consumed after CSUM.
- Assert `rst` after 6 payload bytes of the nominal image.
  - Outputs return to reset values asynchronously.
  - Resending the full image yields the correct two writes and release.
- `LOAD_BASE`=32'hFFFF_FFFC with N=2 → writes to 0xFFFFFFFC then 0x00000000, no error.
